// File: rtl/tt_sweep_capture.sv
// Sequential truth-table characterizer: sweeps the 8 input vectors of a 3-input DUT and
// assembles the sampled outputs into a truth-table code. Optional TT_SWEEP_SYNC_EN adds a 2-flop dut_out synchronizer.
module tt_sweep_capture #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    output logic       dut_in1,
    output logic       dut_in2,
    output logic       dut_in3,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match,
    output logic [7:0] mismatch_mask
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] table_q, table_d;
    logic       match_q, match_d;
    logic [7:0] mask_q, mask_d;
    logic       sample_bit;

`ifdef TT_SWEEP_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], dut_out};
        end
    end

    assign sample_bit = sync_q[1];
`else
    assign sample_bit = dut_out;
`endif

    always_comb begin
        // NOTE: every variable gets a hold default first so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        table_d = table_q;
        match_d = match_q;
        mask_d  = mask_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_SETTLE;
                    idx_d   = 3'd0;
                    cnt_d   = 8'd0;
                    exp_d   = expected;
                    table_d = 8'h00;
                    match_d = 1'b0;
                    mask_d  = 8'h00;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SAMPLE: begin
                // 7-idx equals ~idx for a 3-bit index, so vector 0 lands in the MSB.
                table_d[~idx_q] = sample_bit;
                if (idx_q == 3'd7) begin
                    state_d = S_DONE;
                    match_d = (table_d == exp_q);
                    mask_d  = table_d ^ exp_q;
                end else begin
                    state_d = S_SETTLE;
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = 8'd0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides whatever the active sweep would have done this cycle.
        if (abort && (state_q == S_SETTLE || state_q == S_SAMPLE)) begin
            state_d = S_IDLE;
            idx_d   = 3'd0;
            cnt_d   = 8'd0;
            table_d = 8'h00;
            match_d = 1'b0;
            mask_d  = 8'h00;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 8'd0;
            exp_q   <= 8'h00;
            table_q <= 8'h00;
            match_q <= 1'b0;
            mask_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            table_q <= table_d;
            match_q <= match_d;
            mask_q  <= mask_d;
        end
    end

    assign {dut_in1, dut_in2, dut_in3} = idx_q;
    assign busy          = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done          = (state_q == S_DONE);
    assign table_out     = table_q;
    assign match         = match_q;
    assign mismatch_mask = mask_q;

endmodule

// File: doc/tt_sweep_capture.md
# tt_sweep_capture

Sequential truth-table characterizer for 3-input combinational gate networks such as the 0xE1 NOR/NOT circuit. It drives all eight input vectors into a device under test (DUT), waits a programmable settle time for each, and samples the DUT output. It assembles the samples into the 8-bit truth-table code and compares it against an expected code. It sits in the circuit-score test harness, on the observing side of each synthesized 3-input design.

## Interface

Parameters:

- SETTLE_CYCLES, default 4: cycles each input vector is held before sampling.
  - Legal range is 1..255.
  - Must be ≥3 when TT_SWEEP_SYNC_EN is defined.

Ports:

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep. Sampled only when busy=0.
- abort  input  1  synchronous cancel of a sweep in progress.
- expected  input  8  reference truth-table code. Captured into an internal register on accepted start.
- dut_in1  output  1  DUT input in1; bit 2 of the vector index.
- dut_in2  output  1  DUT input in2; bit 1 of the vector index.
- dut_in3  output  1  DUT input in3; bit 0 of the vector index.
- dut_out  input  1  DUT output.
- busy  output  1  high from the cycle after accepted start until the cycle done pulses.
- done  output  1  one-cycle pulse when a sweep completes.
- table_out  output  8  captured truth-table code.
- match  output  1  table_out == captured expected. Valid from done onward.
- mismatch_mask  output  8  table_out ^ captured expected.

## Operation

- Vector index: idx = {dut_in1, dut_in2, dut_in3}, swept from 0 to 7.
- Sample placement: the sample for idx is written to table_out[7-idx], so the idx=0 result is the MSB. The 0xE1 circuit therefore yields 0xE1.
- FSM states:
  - IDLE: busy=0, DUT inputs held at 000. start=1 → SETTLE with idx=0, settle counter=0, expected captured, table_out cleared to 0.
  - SETTLE: counter increments each cycle. When counter==SETTLE_CYCLES-1 → SAMPLE.
  - SAMPLE: write the sampled dut_out into table_out[7-idx].
    - If idx==7 → DONE.
    - Else idx+1, counter=0 → SETTLE.
  - DONE: assert done for one cycle, update match and mismatch_mask → IDLE.
- DUT inputs change only on the clock edge that enters SETTLE. They are stable throughout SAMPLE.
- match and mismatch_mask hold their values until the next accepted start, then clear to 0.
- abort=1 while busy → IDLE next edge.
  - table_out, match and mismatch_mask clear to 0; DUT inputs return to 000.
  - No done pulse.
- abort has priority over start in the same cycle.
- start while busy is ignored. It is not queued.
- start and abort in IDLE: abort wins, nothing happens.

## Timing

- Reset values: dut_in1/2/3=0, busy=0, done=0, table_out=0x00, match=0, mismatch_mask=0x00, FSM=IDLE.
- Reset mid-sweep: all of the above take effect immediately (asynchronous). No done pulse.
- Per-vector cost is SETTLE_CYCLES+1 cycles.
- start accepted on edge T → done high in cycle T+8·(SETTLE_CYCLES+1). With the default this is T+40.
- busy is high for exactly 8·(SETTLE_CYCLES+1) cycles per completed sweep.
- A back-to-back start is accepted in the cycle after done.

## Configuration

- TT_SWEEP_SYNC_EN defined: dut_out passes through a 2-flop synchronizer, reset to 0, before sampling. This is for DUTs that are asynchronous to clk. The sampled value lags dut_out by 2 cycles, so SETTLE_CYCLES ≥ 3 is required.
- TT_SWEEP_SYNC_EN undefined: dut_out is sampled directly in the SAMPLE cycle. Cycle counts are unchanged in both builds.

## Test plan

- 0xE1 behavioral DUT, expected=0xE1, start at T → done at T+40, table_out=0xE1, match=1, mismatch_mask=0x00.
- Same DUT, expected=0xE0 → table_out=0xE1, match=0, mismatch_mask=0x01.
- Constant-1 DUT, SETTLE_CYCLES=1 → done at T+16, table_out=0xFF. Check the dut_in sequence 000,001,…,111, each held 2 cycles.
- start re-pulsed at T+5 and T+20 → ignored, single done at T+40. abort at T+10 → busy=0 at T+11, table_out=0x00, no done.
- rst_n low at T+25 → all outputs at reset values immediately. New start after release → normal sweep, table_out=0xE1.
- TT_SWEEP_SYNC_EN, SETTLE_CYCLES=4, 0xE1 DUT → table_out=0xE1, done at T+40.
